// File: rtl/bin2bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter:
// FSM state encoding, the saturation digit and the bit-counter width helper.
package bin2bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Counter must hold BIN_W itself, hence the +1.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the score logic (master) and the converter (slave).
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  ready, busy, done, bcd, overflow, blank
    );

    modport slave (
        input  start, bin,
        output ready, busy, done, bcd, overflow, blank
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Corrected value never exceeds 12, so no carry leaves the digit.
    always_comb begin
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle shift-add-3 binary-to-BCD converter, one input bit per clock,
// with overflow saturation to all nines and a leading-zero blank mask.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int CW = cnt_width(BIN_W);
    localparam int SW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [BIN_W-1:0]  r_shift;
    logic [SW-1:0]     r_scratch;
    logic              r_ovf;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_bcd;
    logic              r_overflow;
    logic [DIGITS-1:0] r_blank;

    logic [SW-1:0]     w_adj;
    logic [SW-1:0]     w_scr_nxt;
    logic              w_ovf_nxt;
    logic              w_last;
    logic [SW-1:0]     w_res_bcd;
    logic [DIGITS-1:0] w_res_blank;
    logic              w_ready;
    logic              w_busy;
    logic              w_done;

    // Digit i is blanked when it and every digit above it are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [SW-1:0] v);
        logic z;
        z          = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z             = z & (v[4*i +: 4] == 4'd0);
            blank_mask[i] = z;
        end
    endfunction

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*gi +: 4]),
            .o_digit (w_adj[4*gi +: 4])
        );
    end

    assign w_scr_nxt   = {w_adj[SW-2:0], r_shift[BIN_W-1]};
    assign w_ovf_nxt   = r_ovf | w_adj[SW-1];
    assign w_last      = (r_cnt == CW'(1));
    assign w_res_bcd   = w_ovf_nxt ? {DIGITS{BCD_NINE}} : w_scr_nxt;
    assign w_res_blank = w_ovf_nxt ? '0 : blank_mask(w_scr_nxt);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_nxt = bus.start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_state_nxt = w_last ? ST_DONE : ST_SHIFT;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_SHIFT: w_busy  = 1'b1;
            ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
                w_busy  = 1'b0;
                w_done  = 1'b0;
            end
        endcase
    end

    // Shift datapath; the result registers load on the last shift so they are valid with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_scratch  <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_blank    <= BLANK_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.bin;
                        r_scratch <= '0;
                        r_ovf     <= 1'b0;
                        r_cnt     <= CW'(BIN_W);
                    end
                end
                ST_SHIFT: begin
                    r_shift   <= r_shift << 1;
                    r_scratch <= w_scr_nxt;
                    r_ovf     <= w_ovf_nxt;
                    r_cnt     <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_bcd      <= w_res_bcd;
                        r_overflow <= w_ovf_nxt;
                        r_blank    <= w_res_blank;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready    = w_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_overflow;
    assign bus.blank    = r_blank;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: two instances (10-bit and 14-bit input, 4 digits)
// checked every cycle against a decimal-arithmetic timeline model, plus literal checks.
module tb_bin2bcd_seq;

    typedef struct packed {
        logic [15:0] b;
        logic        o;
        logic [3:0]  bl;
    } res_t;

    localparam res_t RST_RES = '{b: 16'h0000, o: 1'b0, bl: 4'b1110};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_r   [2];
    logic        start_r [2];
    logic [31:0] bin_r   [2];

    bin2bcd_seq_if #(.BIN_W(10), .DIGITS(4)) ifa ();
    bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) ifb ();

    assign ifa.start = start_r[0];
    assign ifa.bin   = bin_r[0][9:0];
    assign ifb.start = start_r[1];
    assign ifb.bin   = bin_r[1][13:0];

    bin2bcd_seq #(.BIN_W(10), .DIGITS(4)) dut_a (.clk(clk), .rst(rst_r[0]), .bus(ifa));
    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_b (.clk(clk), .rst(rst_r[1]), .bus(ifb));

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_cyc = 0;
    int   busy_left [2];
    res_t q0 [$];
    res_t q1 [$];
    res_t held [2];
    bit   acc [2];

    logic        o_done [2];
    logic        o_ready[2];
    logic        o_busy [2];
    logic        o_ovf  [2];
    logic [15:0] o_bcd  [2];
    logic [3:0]  o_blank[2];

    function automatic int bw(input int d);
        return (d == 0) ? 10 : 14;
    endfunction

    // Reference conversion from plain decimal arithmetic.
    function automatic res_t ref_conv(input int unsigned v);
        res_t        r;
        int unsigned t;
        logic        z;
        r = '0;
        if (v > 9999) begin
            r.b  = 16'h9999;
            r.o  = 1'b1;
            r.bl = 4'b0000;
        end else begin
            t = v;
            for (int i = 0; i < 4; i++) begin
                r.b[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
            z = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                z       = z & (r.b[4*i +: 4] == 4'd0);
                r.bl[i] = z;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, n_cyc);
        end
    endtask

    task automatic sample();
        o_done[0]  = ifa.done;  o_ready[0] = ifa.ready; o_busy[0] = ifa.busy;
        o_ovf[0]   = ifa.overflow; o_bcd[0] = ifa.bcd;  o_blank[0] = ifa.blank;
        o_done[1]  = ifb.done;  o_ready[1] = ifb.ready; o_busy[1] = ifb.busy;
        o_ovf[1]   = ifb.overflow; o_bcd[1] = ifb.bcd;  o_blank[1] = ifb.blank;
    endtask

    // Timeline model: busy_left counts the cycles of a conversion still to come (SHIFT..DONE).
    task automatic model_step(input int d);
        res_t e;
        if (rst_r[d]) begin
            busy_left[d] = 0;
            if (d == 0) q0.delete(); else q1.delete();
            held[d] = RST_RES;
        end
        if (busy_left[d] == 1) begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            held[d] = e;
        end
        chk($sformatf("ready[%0d]", d), 32'(o_ready[d]), 32'(busy_left[d] == 0));
        chk($sformatf("busy[%0d]", d),  32'(o_busy[d]),  32'(busy_left[d] != 0));
        chk($sformatf("done[%0d]", d),  32'(o_done[d]),  32'(busy_left[d] == 1));
        chk($sformatf("bcd[%0d]", d),   32'(o_bcd[d]),   32'(held[d].b));
        chk($sformatf("overflow[%0d]", d), 32'(o_ovf[d]), 32'(held[d].o));
        chk($sformatf("blank[%0d]", d), 32'(o_blank[d]), 32'(held[d].bl));
        acc[d] = 1'b0;
        if (!rst_r[d]) begin
            if (busy_left[d] > 0) begin
                busy_left[d]--;
            end else if (start_r[d]) begin
                busy_left[d] = bw(d) + 1;
                e = ref_conv(bin_r[d]);
                if (d == 0) q0.push_back(e); else q1.push_back(e);
                acc[d] = 1'b1;
            end
        end
    endtask

    // One clock: observe and check at the falling edge, return just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        n_cyc++;
        sample();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input int d, input int v, output res_t got);
        int c0;
        int lat;
        bit seen;
        got = '0;
        lat = 0;
        seen = 1'b0;
        bin_r[d] = 32'(v);
        start_r[d] = 1'b1;
        cyc();
        chk($sformatf("accept[%0d] %0d", d, v), 32'(acc[d]), 32'd1);
        c0 = n_cyc;
        start_r[d] = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc();
            if (o_done[d]) begin
                seen  = 1'b1;
                lat   = n_cyc - c0;
                got.b = o_bcd[d]; got.o = o_ovf[d]; got.bl = o_blank[d];
            end
        end
        chk($sformatf("done_seen[%0d] %0d", d, v), 32'(seen), 32'd1);
        chk($sformatf("latency[%0d] %0d", d, v), 32'(lat), 32'(bw(d) + 1));
    endtask

    initial begin
        res_t r;
        int   dones;
        int   done_k;
        bit   ok;

        for (int d = 0; d < 2; d++) begin
            rst_r[d] = 1'b1; start_r[d] = 1'b0; bin_r[d] = 32'd0;
            busy_left[d] = 0; held[d] = RST_RES; acc[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc();
        chk("rst_bcd",   32'(o_bcd[0]),   32'h0000);
        chk("rst_blank", 32'(o_blank[0]), 32'b1110);
        chk("rst_ready", 32'(o_ready[0]), 32'd1);
        rst_r[0] = 1'b0;
        rst_r[1] = 1'b0;
        cyc();

        conv(0, 0, r);
        chk("bin0_bcd", 32'(r.b), 32'h0000); chk("bin0_ovf", 32'(r.o), 32'd0); chk("bin0_blank", 32'(r.bl), 32'b1110);
        conv(0, 1023, r);
        chk("b1023_bcd", 32'(r.b), 32'h1023); chk("b1023_ovf", 32'(r.o), 32'd0); chk("b1023_blank", 32'(r.bl), 32'b0000);
        conv(0, 999, r);
        chk("b999_bcd", 32'(r.b), 32'h0999); chk("b999_blank", 32'(r.bl), 32'b1000);
        conv(0, 7, r);
        chk("b7_bcd", 32'(r.b), 32'h0007); chk("b7_blank", 32'(r.bl), 32'b1110);

        conv(1, 12345, r);
        chk("w14_12345_bcd", 32'(r.b), 32'h9999); chk("w14_12345_ovf", 32'(r.o), 32'd1); chk("w14_12345_blank", 32'(r.bl), 32'b0000);
        conv(1, 9999, r);
        chk("w14_9999_bcd", 32'(r.b), 32'h9999); chk("w14_9999_ovf", 32'(r.o), 32'd0); chk("w14_9999_blank", 32'(r.bl), 32'b0000);

        // Starts during SHIFT (k=3) and during DONE (k=11) must be ignored.
        bin_r[0] = 32'd500; start_r[0] = 1'b1;
        cyc();
        dones = 0; done_k = 0; r = '0;
        for (int k = 1; k <= 14; k++) begin
            start_r[0] = (k == 3 || k == 11);
            if (k == 3 || k == 11) bin_r[0] = 32'd42;
            cyc();
            if (o_done[0]) begin
                dones++;
                done_k = k;
                r.b = o_bcd[0];
            end
            if (k == 12) chk("ready_after_done", 32'(o_ready[0]), 32'd1);
        end
        start_r[0] = 1'b0;
        chk("ignore_done_count", 32'(dones), 32'd1);
        chk("ignore_done_cycle", 32'(done_k), 32'd11);
        chk("ignore_bcd", 32'(r.b), 32'h0500);
        conv(0, 42, r);
        chk("b42_bcd", 32'(r.b), 32'h0042);

        // Reset in the middle of a conversion.
        bin_r[0] = 32'd321; start_r[0] = 1'b1;
        cyc();
        start_r[0] = 1'b0;
        for (int k = 1; k <= 4; k++) cyc();
        rst_r[0] = 1'b1;
        cyc();
        chk("midrst_bcd",   32'(o_bcd[0]),   32'h0000);
        chk("midrst_ready", 32'(o_ready[0]), 32'd1);
        rst_r[0] = 1'b0;
        dones = 0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (o_done[0]) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        conv(0, 321, r);
        chk("b321_bcd", 32'(r.b), 32'h0321);

        // Back-to-back sweep with start held high.
        dones = 0;
        for (int v = 0; v < 1024; v++) begin
            bin_r[0] = 32'(v);
            start_r[0] = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 40 && !ok; k++) begin
                cyc();
                if (o_done[0]) dones++;
                if (acc[0]) ok = 1'b1;
            end
            chk($sformatf("sweep_accept %0d", v), 32'(ok), 32'd1);
        end
        start_r[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (o_done[0]) dones++;
        end
        chk("sweep_done_count", 32'(dones), 32'd1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using the shift-add-3 (double-dabble) method, one input bit per clock.
- Successor to the fixed 10-bit combinational converter: generic BIN_W/DIGITS, a start/ready/done handshake, overflow saturation and leading-zero blanking.
- Sits between the score/counter logic and the seven-segment display driver.

Parameters:
- BIN_W, 10, binary input width (1..20).
- DIGITS, 4, BCD output digit count (1..6).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; accepted only while ready=1.
- bin  input  BIN_W  unsigned binary value; sampled on accepted start.
- ready  output  1  high in IDLE; block can accept start.
- busy  output  1  high while conversion in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse; bcd/overflow/blank valid and updated this cycle.
- bcd  output  4*DIGITS  packed BCD result; digit 0 = bits [3:0]; held between conversions.
- overflow  output  1  last value exceeded 10^DIGITS-1; held with bcd.
- blank  output  DIGITS  per-digit leading-zero blank mask for the display; held with bcd.

Behaviour:
- Reset (async, rst=1): state IDLE, bcd=0, overflow=0, blank={DIGITS-1 ones, LSB 0}, done=0, busy=0, ready=1, internal shift/scratch/counter cleared.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: ready=1. When start=1, latch bin into shift register, clear BCD scratch and sticky ovf flag, load bit counter=BIN_W, go to SHIFT.
- SHIFT, one bit per cycle:
  - First, each scratch digit >=5 gets +3.
  - Then {scratch, shift} is shifted left 1; the shift-register MSB enters scratch bit 0.
  - If a 1 leaves the top scratch bit, sticky ovf is set.
  - Counter decrements; when it reaches 1 on this cycle, go to DONE.
  - Exactly BIN_W SHIFT cycles.
- DONE, one cycle:
  - done=1.
  - bcd = ovf ? all digits 9 : scratch.
  - overflow = ovf.
  - blank computed from the final bcd.
  - Next state IDLE.
- Latency: start sampled at edge N -> done high in cycle N+BIN_W+1; ready again the following cycle. Throughput: one conversion per BIN_W+2 cycles.
- start while busy, including the DONE cycle: ignored, no queueing. bin changes while busy: no effect.
- blank[i]=1 iff digit i and every higher digit are 0, for i>=1. blank[0] is always 0. With overflow=1, blank = all 0.
- Outputs bcd/overflow/blank change only in the DONE cycle or on reset.
- Reset mid-conversion: immediate return to IDLE with reset values; no done pulse; the partial result is discarded.
- Width rule: scratch width 4*DIGITS. Add-3 is 4-bit and never carries across digits; the corrected digit value is at most 12.

Decomposition:
- Package bin2bcd_pkg: state encoding constants (ST_IDLE, ST_SHIFT, ST_DONE, 2-bit), the constant BCD_NINE=4'd9, and a counter-width helper function (clog2(BIN_W+1)).
- One natural sub-module: bcd_digit_adj, combinational, 4-bit in/out, applies +3 when in>=5. Instantiated DIGITS times in a generate loop.

Test Plan:
- Defaults, bin=0, start pulse -> done exactly 11 cycles after start edge; bcd=16'h0000, overflow=0, blank=4'b1110.
- Defaults, bin=1023 -> bcd=16'h1023, blank=4'b0000, overflow=0. Then bin=999 -> bcd=16'h0999, blank=4'b1000. Then bin=7 -> bcd=16'h0007, blank=4'b1110.
- BIN_W=14, DIGITS=4, bin=12345 -> overflow=1, bcd=16'h9999, blank=4'b0000. Then bin=9999 -> overflow=0, bcd=16'h9999.
- Defaults, start with bin=500, then start with bin=42 at cycle 3 and again in the DONE cycle -> single done, bcd=16'h0500; ready returns 1 cycle after done; the next start converts normally.
- Defaults, start with bin=321, assert rst at cycle 5 for 1 cycle -> no done pulse; bcd=0, ready=1 immediately. A fresh start with bin=321 -> bcd=16'h0321.
- Exhaustive sweep bin=0..1023 back-to-back, start asserted on every ready cycle -> each bcd matches the reference decimal conversion; the done count equals 1024.
